rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 69 ++++++
 tb/tb_rom_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port round-robin arbiter in front of a synchronous ROM.
// One read every 3 cycles: IDLE (arbitrate) -> ADDR (ROM samples) -> DATA (capture).
module rom_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int ROM_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              valid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state;
    logic last, cur, win0;
    logic [ROM_W-DATA_W-1:0] unused_hi;

    assign unused_hi = rom_data[ROM_W-1:DATA_W];
    // last=1 means port 1 was granted last, so port 0 wins a tie
    assign win0 = req0 & (~req1 | last);
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            rdata    <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            valid0   <= 1'b0;
            valid1   <= 1'b0;
            last     <= 1'b1;
            cur      <= 1'b0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            case (state)
                IDLE: if (req0 | req1) begin
                    state    <= ADDR;
                    rom_addr <= win0 ? addr0 : addr1;
                    gnt0     <= win0;
                    gnt1     <= ~win0;
                    cur      <= ~win0;
                    last     <= ~win0;
                end
                ADDR: state <= DATA;
                DATA: begin
                    state  <= IDLE;
                    rdata  <= rom_data[DATA_W-1:0];
                    valid0 <= ~cur;
                    valid1 <= cur;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven vectors plus corner sequences; a negedge monitor
// pops expected grants/reads from scoreboard queues and checks port, data and cycle.
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst, req0, req1;
    logic [6:0]  addr0, addr1, rom_addr;
    logic        gnt0, gnt1, valid0, valid1, busy;
    logic [31:0] rdata;
    logic [47:0] rom_data;
    logic [47:0] mem [128];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        bit          port;
        logic [6:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t gq[$];
    exp_t vq[$];

    typedef struct {
        bit          r0, r1;
        logic [6:0]  a0, a1;
        bit          port;
        logic [31:0] data;
    } vec_t;
    vec_t tv[9];

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .valid0(valid0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .valid1(valid1),
        .rdata(rdata), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit p, input logic [6:0] a, input logic [31:0] d, input int c, input bit with_valid);
        exp_t e;
        e.port = p; e.addr = a; e.data = d; e.cyc = c;
        gq.push_back(e);
        if (with_valid) begin
            e.cyc = c + 2;
            vq.push_back(e);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        exp_t e;
        if (gnt0 & gnt1) chk("gnt_overlap", {gnt0, gnt1}, 2'b01);
        if (valid0 & valid1) chk("valid_overlap", {valid0, valid1}, 2'b01);
        if (gnt0 | gnt1) begin
            if (gq.size() == 0) begin
                errors++; checks++;
                $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b expected none (cycle %0d)", gnt0, gnt1, cyc);
            end else begin
                e = gq.pop_front();
                chk("gnt_port", gnt1, e.port);
                chk("rom_addr", rom_addr, e.addr);
                chk("gnt_cycle", cyc, e.cyc);
            end
        end
        if (valid0 | valid1) begin
            if (vq.size() == 0) begin
                errors++; checks++;
                $display("FAIL valid_unexpected: got valid0=%0b valid1=%0b expected none (cycle %0d)", valid0, valid1, cyc);
            end else begin
                e = vq.pop_front();
                chk("valid_port", valid1, e.port);
                chk("rdata", rdata, e.data);
                chk("valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt_valid"}, {gnt0, gnt1, valid0, valid1}, 4'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_rom_addr"}, rom_addr, 7'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = {16'hFFFF, 32'hCAFE0000 | i};
        mem[5]   = 48'h1234_DEADBEEF;
        mem[9]   = 48'hFFFF_12345678;
        mem[127] = 48'hABCD_77777F7F;
        // reset leaves the pointer at port 1, so the first tie goes to port 0
        tv[0] = '{1, 0, 7'h05, 7'h00, 0, 32'hDEADBEEF};
        tv[1] = '{0, 1, 7'h00, 7'h7F, 1, 32'h77777F7F};
        tv[2] = '{1, 1, 7'h03, 7'h04, 0, 32'hCAFE0003};
        tv[3] = '{1, 1, 7'h06, 7'h08, 1, 32'hCAFE0008};
        tv[4] = '{1, 0, 7'h09, 7'h00, 0, 32'h12345678};
        tv[5] = '{0, 1, 7'h00, 7'h00, 1, 32'hCAFE0000};
        tv[6] = '{1, 1, 7'h0A, 7'h0B, 0, 32'hCAFE000A};
        tv[7] = '{1, 0, 7'h0C, 7'h0B, 0, 32'hCAFE000C};
        tv[8] = '{1, 1, 7'h0D, 7'h0E, 1, 32'hCAFE000E};

        rst = 1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst = 0;
        @(negedge clk);

        foreach (tv[i]) begin
            req0 = tv[i].r0; req1 = tv[i].r1; addr0 = tv[i].a0; addr1 = tv[i].a1;
            push(tv[i].port, tv[i].port ? tv[i].a1 : tv[i].a0, tv[i].data, cyc + 1, 1);
            @(posedge clk);
            #1 req0 = 0; req1 = 0;
            chk("busy_addr", busy, 1'b1);
            repeat (2) @(posedge clk);
            @(negedge clk);
        end

        // sustained ties: last grant was port 1, so grants run 0,1,0,1 every 3 cycles
        req0 = 1; req1 = 1; addr0 = 7'h01; addr1 = 7'h02;
        for (int i = 0; i < 4; i++)
            push(i[0], i[0] ? 7'h02 : 7'h01, i[0] ? 32'hCAFE0002 : 32'hCAFE0001, cyc + 1 + 3 * i, 1);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // req1 raised during ADDR must wait until the IDLE cycle carrying valid0
        req0 = 1; addr0 = 7'h14;
        push(0, 7'h14, 32'hCAFE0014, cyc + 1, 1);
        push(1, 7'h15, 32'hCAFE0015, cyc + 4, 1);
        @(posedge clk);
        #1 req0 = 0; req1 = 1; addr1 = 7'h15;
        repeat (3) @(posedge clk);
        #1 req1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset during DATA aborts the read: grant seen, no valid
        req0 = 1; addr0 = 7'h1E;
        push(0, 7'h1E, 32'h0, cyc + 1, 0);
        @(posedge clk);
        #1 req0 = 0;
        @(posedge clk);
        #1 chk("busy_data", busy, 1'b1);
        rst = 1;
        #1 chk_reset_outputs("abort");
        @(negedge clk) rst = 0;
        repeat (3) @(negedge clk);

        req0 = 1; req1 = 1; addr0 = 7'h05; addr1 = 7'h09;
        push(0, 7'h05, 32'hDEADBEEF, cyc + 1, 1);
        @(posedge clk);
        #1 req0 = 0; req1 = 0;
        repeat (6) @(negedge clk);

        chk("grants_outstanding", gq.size(), 0);
        chk("valids_outstanding", vq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
